// File: rtl/cic_interp_if.sv
// Valid/ready sample bus for the CIC interpolator: low-rate input strobe side plus high-rate output side.
interface cic_interp_if #(
  parameter int unsigned INPUT_WIDTH  = 14,
  parameter int unsigned OUTPUT_WIDTH = 14
);
  logic signed [INPUT_WIDTH-1:0]  in_data;
  logic                           in_valid;
  logic                           in_ready;
  logic signed [OUTPUT_WIDTH-1:0] out_data;
  logic                           out_valid;
  logic                           underrun;

  modport master (
    output in_data, in_valid,
    input  in_ready, out_data, out_valid, underrun
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, out_data, out_valid, underrun
  );
endinterface

// File: rtl/cic_interp.sv
// N-stage CIC interpolator: strobed low-rate input, zero-stuff by R, one output per clock.
// Optional macro CIC_INTERP_ROUND_EN: round half up instead of truncating when the output is narrowed.
module cic_interp #(
  parameter int unsigned N            = 2,
  parameter int unsigned R            = 16,
  parameter int unsigned INPUT_WIDTH  = 14,
  parameter int unsigned OUTPUT_WIDTH = 14
) (
  input  logic       clk,
  input  logic       rst,
  cic_interp_if.slave bus
);
  localparam int unsigned LOG2R = $clog2(R);
  localparam int unsigned W     = INPUT_WIDTH + N * LOG2R + 1;
  localparam int unsigned G     = INPUT_WIDTH + (N - 1) * LOG2R;
  localparam int          SHIFT = int'(G) - int'(OUTPUT_WIDTH);

  logic [LOG2R-1:0]               phase;
  logic [LOG2R-1:0]               phase_nxt;
  logic                           ready_q;
  logic                           strobe_d;
  logic                           valid_q;
  logic                           underrun_q;
  logic signed [W-1:0]            x_c;
  logic signed [W-1:0]            comb [N+1];
  logic signed [W-1:0]            dly  [N];
  logic signed [W-1:0]            stuff;
  logic signed [W-1:0]            integ [N];
  logic signed [OUTPUT_WIDTH-1:0] scaled_c;
  logic signed [OUTPUT_WIDTH-1:0] out_q;

  // R is a power of two, so the phase counter wraps naturally at R-1.
  assign phase_nxt = phase + LOG2R'(1);
  assign x_c       = bus.in_valid ? W'(bus.in_data) : '0;

  if (SHIFT > 0) begin : g_shr
`ifdef CIC_INTERP_ROUND_EN
    localparam logic signed [W-1:0] HALF = W'(1) << (SHIFT - 1);
    logic signed [W-1:0] biased_c;
    assign biased_c = integ[N-1] + HALF;
    assign scaled_c = OUTPUT_WIDTH'(biased_c >>> SHIFT);
`else
    assign scaled_c = OUTPUT_WIDTH'(integ[N-1] >>> SHIFT);
`endif
  end else if (SHIFT < 0) begin : g_shl
    logic signed [G-1:0] full_c;
    assign full_c   = G'(integ[N-1]);
    assign scaled_c = OUTPUT_WIDTH'(full_c) <<< (int'(OUTPUT_WIDTH) - int'(G));
  end else begin : g_pass
    assign scaled_c = OUTPUT_WIDTH'(integ[N-1]);
  end

  // Strobe timing, comb section (strobe edges only), stuffer, integrators and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase      <= '0;
      ready_q    <= 1'b0;
      strobe_d   <= 1'b0;
      valid_q    <= 1'b0;
      underrun_q <= 1'b0;
      stuff      <= '0;
      out_q      <= '0;
      for (int k = 0; k <= int'(N); k++) comb[k] <= '0;
      for (int k = 0; k < int'(N); k++) begin
        dly[k]   <= '0;
        integ[k] <= '0;
      end
    end else begin
      phase    <= phase_nxt;
      ready_q  <= (phase_nxt == LOG2R'(R - 1));
      strobe_d <= ready_q;
      valid_q  <= 1'b1;
      if (ready_q) begin
        comb[0] <= x_c;
        for (int k = 1; k <= int'(N); k++) begin
          comb[k]  <= comb[k-1] - dly[k-1];
          dly[k-1] <= comb[k-1];
        end
        if (!bus.in_valid) underrun_q <= 1'b1;
      end
      stuff    <= strobe_d ? comb[N] : '0;
      integ[0] <= integ[0] + stuff;
      for (int k = 1; k < int'(N); k++) integ[k] <= integ[k] + integ[k-1];
      out_q    <= scaled_c;
    end
  end

  assign bus.in_ready  = ready_q;
  assign bus.out_valid = valid_q;
  assign bus.underrun  = underrun_q;
  assign bus.out_data  = out_q;
endmodule

// File: tb/tb_cic_interp.sv
// Bench for cic_interp (N=2, R=4): 16-bit full-precision and 14-bit narrowed instances side by side.
module tb_cic_interp;
  localparam int N  = 2;
  localparam int R  = 4;
  localparam int IW = 14;
  localparam int L  = N * R + N + 2;
  localparam int HL = N * (R - 1) + 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic signed [IW-1:0] in_data;
  logic                 in_valid;

  cic_interp_if #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(16)) if16 ();
  cic_interp_if #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(14)) if14 ();

  assign if16.in_data  = in_data;
  assign if16.in_valid = in_valid;
  assign if14.in_data  = in_data;
  assign if14.in_valid = in_valid;

  cic_interp #(.N(N), .R(R), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .bus(if16)
  );
  cic_interp #(.N(N), .R(R), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(14)) u_dut14 (
    .clk(clk), .rst(rst), .bus(if14)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint scale14(input longint y);
`ifdef CIC_INTERP_ROUND_EN
    return (y + 2) >>> 2;
`else
    return y >>> 2;
`endif
  endfunction

  // Impulse response of the interpolator: N-fold convolution of a length-R boxcar.
  longint h [HL];
  initial begin : build_h
    longint t [HL];
    for (int i = 0; i < HL; i++) h[i] = 0;
    h[0] = 1;
    for (int n = 0; n < N; n++) begin
      for (int i = 0; i < HL; i++) begin
        t[i] = 0;
        for (int j = 0; j < R; j++) if (i - j >= 0) t[i] += h[i-j];
      end
      h = t;
    end
  end

  // Scoreboard: each accepted sample pushes its future contributions; one entry is popped per edge.
  longint               exp_q [$];
  int                   m_cnt;
  bit                   m_ready;
  bit                   m_under;
  bit                   s_rst;
  bit                   s_valid;
  logic signed [IW-1:0] s_data;

  initial begin : monitor
    longint y;
    longint x;
    int     idx;
    m_cnt   = 0;
    m_ready = 1'b0;
    m_under = 1'b0;
    forever begin
      @(negedge clk);
      s_rst   = rst;
      s_valid = in_valid;
      s_data  = in_data;
      @(posedge clk);
      #1;
      y = (exp_q.size() > 0) ? exp_q.pop_front() : 0;
      if (s_rst) begin
        exp_q.delete();
        m_cnt   = 0;
        m_ready = 1'b0;
        m_under = 1'b0;
        y       = 0;
        check("sb_valid_rst", if16.out_valid, 0);
      end else begin
        if (m_ready) begin
          x = s_valid ? longint'(s_data) : 0;
          if (!s_valid) m_under = 1'b1;
          for (int k = 0; k < HL; k++) begin
            idx = L - 1 + k;
            while (exp_q.size() <= idx) exp_q.push_back(0);
            exp_q[idx] += x * h[k];
          end
        end
        m_cnt   = (m_cnt + 1) % R;
        m_ready = (m_cnt == R - 1);
        check("sb_valid", if16.out_valid, 1);
      end
      check("sb_out16", if16.out_data, y);
      check("sb_out14", if14.out_data, scale14(y));
      check("sb_ready16", if16.in_ready, m_ready);
      check("sb_ready14", if14.in_ready, m_ready);
      check("sb_under16", if16.underrun, m_under);
      check("sb_under14", if14.underrun, m_under);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Returns just before a strobe edge (in_ready high), bounded to two frames.
  task automatic wait_ready();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2 * R && !ok; i++) begin
      if (if16.in_ready) ok = 1'b1;
      else tick();
    end
    check("ready_seen", ok, 1);
  endtask

  typedef struct {
    logic signed [IW-1:0] x;
    longint               exp16;
    longint               exp14;
  } dc_vec_t;

  dc_vec_t dc_tab [6];
  longint  imp16  [9];
  longint  imp14  [9];

  initial begin : stim
    dc_tab[0] = '{x: 14'sd1000,  exp16: 4000,   exp14: 1000};
    dc_tab[1] = '{x: -14'sd8192, exp16: -32768, exp14: -8192};
    dc_tab[2] = '{x: 14'sd8191,  exp16: 32764,  exp14: 8191};
    dc_tab[3] = '{x: -14'sd1,    exp16: -4,     exp14: -1};
    dc_tab[4] = '{x: 14'sd3,     exp16: 12,     exp14: 3};
    dc_tab[5] = '{x: 14'sd0,     exp16: 0,      exp14: 0};
    imp16 = '{0, 1, 2, 3, 4, 3, 2, 1, 0};
`ifdef CIC_INTERP_ROUND_EN
    imp14 = '{0, 0, 1, 1, 1, 1, 1, 0, 0};
`else
    imp14 = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
`endif

    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = '0;
    repeat (5) tick();
    check("rst_out", if16.out_data, 0);
    check("rst_ready", if16.in_ready, 0);
    check("rst_valid", if16.out_valid, 0);
    check("rst_under", if16.underrun, 0);
    rst = 1'b0;

    // Strobe timing after release: in_ready in cycle R, then every R cycles.
    for (int i = 1; i <= 12; i++) begin
      tick();
      check("phase_ready", if16.in_ready, (i % R) == (R - 1));
      check("phase_valid", if16.out_valid, 1);
      check("phase_out", if16.out_data, 0);
      check("phase_under", if16.underrun, 0);
    end

    // Unit impulse, checked at fixed latency L after the strobe edge.
    wait_ready();
    in_data = 14'sd1;
    tick();
    in_data = '0;
    for (int k = 1; k <= L + 8; k++) begin
      tick();
      if (k >= L - 1) begin
        check("imp16", if16.out_data, imp16[k-L+1]);
        check("imp14", if14.out_data, imp14[k-L+1]);
      end
    end

    // Impulse of 2: peak of i[N] is 8, narrowed output 2 in either rounding mode.
    wait_ready();
    in_data = 14'sd2;
    tick();
    in_data = '0;
    repeat (L + 3) tick();
    check("imp2_peak16", if16.out_data, 8);
    check("imp2_peak14", if14.out_data, 2);
    repeat (3 * R) tick();

    // DC table: settled output equals X * R^(N-1), scaled.
    for (int v = 0; v < 6; v++) begin
      in_data = dc_tab[v].x;
      repeat (12 * R) tick();
      check($sformatf("dc16[%0d]", v), if16.out_data, dc_tab[v].exp16);
      check($sformatf("dc14[%0d]", v), if14.out_data, dc_tab[v].exp14);
    end

    // in_valid low away from a strobe is ignored.
    in_data = 14'sd1000;
    repeat (12 * R) tick();
    wait_ready();
    tick();
    in_valid = 1'b0;
    repeat (R - 2) tick();
    in_valid = 1'b1;
    check("no_underrun", if16.underrun, 0);

    // in_valid low on a strobe: sticky underrun, output dips then re-settles.
    wait_ready();
    in_valid = 1'b0;
    tick();
    in_valid = 1'b1;
    check("underrun_set", if16.underrun, 1);
    repeat (2 * R) tick();
    check("underrun_sticky", if14.underrun, 1);
    repeat (12 * R) tick();
    check("underrun_settle16", if16.out_data, 4000);
    check("underrun_settle14", if14.out_data, 1000);
    check("underrun_hold", if16.underrun, 1);

    // Reset in the middle of an impulse response.
    in_data = '0;
    repeat (12 * R) tick();
    wait_ready();
    in_data = 14'sd1;
    tick();
    in_data = '0;
    repeat (L + 2) tick();
    check("mid_pre_out", if16.out_data, 3);
    rst = 1'b1;
    tick();
    check("mid_rst_out", if16.out_data, 0);
    check("mid_rst_ready", if16.in_ready, 0);
    check("mid_rst_under", if16.underrun, 0);
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("mid_phase_ready", if16.in_ready, (i % R) == (R - 1));
      check("mid_out", if16.out_data, 0);
    end
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
